// File: rtl/imem_loader.sv
// imem_loader: serial program loader for the instruction memory.
// Receives a length header and a stream of instruction words over a 1-bit
// valid/ready link, writes them to sequential addresses and holds the core
// in reset until the whole program is in place.
// Optional checksum stage: define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IW = 10,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic          ser_valid,
    input  logic          ser_data,
    output logic          ser_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_adr,
    output logic [IW-1:0] imem_wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    // The bit counter must reach both the header length and the word length.
    localparam int CW = $clog2(((IW > AW) ? IW : AW) + 1);
    localparam logic [CW-1:0] LEN_LAST  = CW'(AW - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(IW - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        WORD,
        WRITE,
        RUN
`ifdef LOADER_CHECKSUM_EN
        , CHK,
        ERR
`endif
    } state_t;

    state_t          state_q;
    logic [AW-2:0]   len_q;
    logic [IW-2:0]   shift_q;
    logic [CW-1:0]   bitcnt_q;
    logic [AW:0]     remaining_q;
    logic [AW-1:0]   adr_q;
    logic [IW-1:0]   wd_q;
    logic            we_q;
    logic            ready_q;
    logic            cpu_reset_q;
    logic            done_q;
`ifdef LOADER_CHECKSUM_EN
    logic [IW-1:0]   csum_q;
    logic            err_q;
`endif

    logic            take;
    logic [AW-1:0]   len_d;
    logic [IW-1:0]   shift_d;

    // The shift registers keep only the bits already received; the incoming
    // bit completes the value in the same cycle it is accepted.
    assign take    = ser_valid & ready_q;
    assign len_d   = {len_q, ser_data};
    assign shift_d = {shift_q, ser_data};

    assign ser_ready = ready_q;
    assign imem_we   = we_q;
    assign imem_adr  = adr_q;
    assign imem_wd   = wd_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

    // Loader FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            remaining_q <= '0;
            adr_q       <= '0;
            wd_q        <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, RUN
`ifdef LOADER_CHECKSUM_EN
                , ERR
`endif
                : begin
                    if (load_req) begin
                        state_q     <= LEN;
                        ready_q     <= 1'b1;
                        bitcnt_q    <= '0;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q      <= '0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                LEN: begin
                    if (take) begin
                        len_q    <= len_d[AW-2:0];
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LEN_LAST) begin
                            // A zero header means a full memory image.
                            remaining_q <= (len_d == '0) ? {1'b1, {AW{1'b0}}}
                                                         : {1'b0, len_d};
                            adr_q       <= '0;
                            bitcnt_q    <= '0;
                            state_q     <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (take) begin
                        shift_q  <= shift_d[IW-2:0];
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == WORD_LAST) begin
                            wd_q     <= shift_d;
                            we_q     <= 1'b1;
                            ready_q  <= 1'b0;
                            bitcnt_q <= '0;
                            state_q  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    we_q        <= 1'b0;
                    adr_q       <= adr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_q      <= csum_q ^ wd_q;
`endif
                    if (remaining_q == (AW+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q     <= CHK;
                        ready_q     <= 1'b1;
`else
                        state_q     <= RUN;
                        ready_q     <= 1'b0;
                        cpu_reset_q <= 1'b0;
                        done_q      <= 1'b1;
`endif
                    end else begin
                        state_q <= WORD;
                        ready_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        shift_q  <= shift_d[IW-2:0];
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == WORD_LAST) begin
                            bitcnt_q <= '0;
                            ready_q  <= 1'b0;
                            if (shift_d == csum_q) begin
                                state_q     <= RUN;
                                cpu_reset_q <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction interface: receives a program over a 1-bit serial valid/ready link and writes 10-bit instruction words into instruction memory at sequential 8-bit addresses.
- Holds the processor in reset while loading and releases it once the whole program has been written.
- Sits between the chip-level load pins and the instruction memory / core reset.

Parameters:
- IW, 10, instruction word width in bits (4-bit opcode/funct plus 6-bit operand field).
- AW, 8, instruction address width; also the width of the length header.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- load_req  in  1  single-cycle pulse that starts a program load
- ser_valid  in  1  serial bit valid
- ser_data  in  1  serial bit, MSB first
- ser_ready  out  1  loader accepts a bit this cycle
- imem_we  out  1  instruction memory write enable
- imem_adr  out  AW  instruction memory write address
- imem_wd  out  IW  instruction memory write data
- cpu_reset  out  1  reset to the processor core, active-high
- done  out  1  program loaded and core running
- err  out  1  checksum failure (only when the optional feature is enabled)

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset values: state IDLE, ser_ready=0, imem_we=0, imem_adr=0, imem_wd=0, cpu_reset=1, done=0, err=0. All internal counters and shift registers are cleared.
- Handshake: a bit transfers on a rising clk edge where ser_valid & ser_ready. When ser_ready=0, ser_valid and ser_data are ignored.
- IDLE:
  - cpu_reset=1, ser_ready=0.
  - load_req -> LEN.
- LEN:
  - ser_ready=1; shift in 8 bits, MSB first, into len.
  - On the 8th accepted bit: remaining=len, with len=0 meaning 256. Then imem_adr=0, bitcnt=0, go to WORD.
- WORD:
  - ser_ready=1; shift IW bits, MSB first, into a shift register.
  - On the IW-th accepted bit: imem_wd is loaded with the complete word, go to WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, ser_ready=0, imem_adr = current address.
  - On exit: imem_adr increments, wrapping 255->0; remaining decrements.
  - If remaining was 1 -> RUN (or CHK when LOADER_CHECKSUM_EN is defined); otherwise -> WORD.
- RUN:
  - cpu_reset=0, done=1, ser_ready=0.
  - load_req -> LEN, with cpu_reset=1 and done=0 in the same cycle LEN is entered.
- Latency: the last bit of a word accepted at edge t gives imem_we=1 in cycle t+1. No bit is accepted during WRITE, so ser_ready drops for exactly one cycle per word.
- load_req in LEN/WORD/WRITE/CHK is ignored; a load in progress is never restarted except by reset.
- Gaps in ser_valid may occur at any point; the FSM simply waits with counters held.
- imem_wd holds its last value outside WRITE; imem_we is never high outside WRITE.
- Boundaries:
  - len=1 writes only address 0.
  - len=0 writes addresses 0..255; imem_adr wraps to 0 as the FSM leaves the final WRITE.
  - Reset asserted mid-load aborts immediately: a partial word is discarded, imem_we drops asynchronously, cpu_reset=1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 10-bit XOR of all written words is kept, cleared on entry to LEN.
  - After the last WRITE, state CHK (ser_ready=1) receives IW checksum bits, MSB first.
  - Match -> RUN.
  - Mismatch -> ERR: err=1, cpu_reset=1, done=0, ser_ready=0. load_req from ERR -> LEN and clears err.
- Undefined: no CHK or ERR states, err tied to 0, last WRITE goes straight to RUN.

Test Plan:
- Reset, then idle for 20 cycles -> cpu_reset=1, done=0, imem_we never high, ser_ready=0.
- load_req; len=8'h02; words 10'h3A5 and 10'h04C sent back-to-back -> imem_we pulses at adr 0 (wd 3A5) and adr 1 (wd 04C), each 1 cycle after that word's 10th bit; then done=1, cpu_reset=0.
- len=8'h00 with 256 words where word k=k -> 256 writes at addresses 0..255, wd=k; imem_adr ends at 0; done=1.
- Random ser_valid gaps (50% duty) with len=3 -> same writes and data as the gap-free run; ser_ready=0 in every WRITE cycle.
- Reset asserted after 5 bits of word 1, then a fresh load with len=1 and word 10'h2FF -> no write from the aborted load; single write at adr 0 with wd 2FF.
- With LOADER_CHECKSUM_EN: words 10'h001, 10'h002 then checksum 10'h003 -> done=1. Same words with checksum 10'h000 -> err=1, cpu_reset=1, done=0; a following load_req clears err.
